// File: rtl/kred_share_arb.sv
// Shares one fixed-latency Kyber reducer among N_REQ requesters, with round-robin arbitration
// and per-requester response FIFOs. Define KRED_ARB_PRIO_EN to give requester 0 strict priority.
module kred_share_arb #(
  parameter int N_REQ      = 4,
  parameter int RED_LAT    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = 24,
  parameter int RW         = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       red_in,
  input  logic [RW-1:0]       red_out,
  output logic [N_REQ-1:0]    resp_valid,
  output logic [N_REQ*RW-1:0] resp_data,
  input  logic [N_REQ-1:0]    resp_ready,
  output logic                busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef KRED_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      credit_q [N_REQ];
  logic [CW-1:0]      credit_d [N_REQ];
  logic [RED_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]      tag_id_q [RED_LAT];
  logic [IW-1:0]      tag_id_d [RED_LAT];
  logic [RW-1:0]      mem_q [N_REQ][FIFO_DEPTH];
  logic [RW-1:0]      mem_d [N_REQ][FIFO_DEPTH];
  logic [CW-1:0]      wr_ptr_q [N_REQ];
  logic [CW-1:0]      wr_ptr_d [N_REQ];
  logic [CW-1:0]      rd_ptr_q [N_REQ];
  logic [CW-1:0]      rd_ptr_d [N_REQ];
  logic [N_REQ-1:0]   eligible, fifo_push, fifo_pop, fifo_empty;
  logic               grant;
  logic [IW-1:0]      win_id;
  int                 cand;

  // Credits cap in-flight plus buffered results, so a push never meets a full FIFO.
  always_comb begin
    grant  = 1'b0;
    win_id = '0;
    cand   = 0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && (credit_q[i] < CW'(FIFO_DEPTH));
    if (PRIO_EN && eligible[0]) begin
      grant = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = (int'(ptr_q) + k) % N_REQ;
        if (!grant && eligible[cand] && !(PRIO_EN && cand == 0)) begin
          grant  = 1'b1;
          win_id = IW'(cand);
        end
      end
    end
    if (rst) grant = 1'b0;

    ptr_d = ptr_q;
    if (grant && !(PRIO_EN && win_id == '0))
      ptr_d = (win_id == IW'(N_REQ - 1)) ? '0 : win_id + 1'b1;

    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = grant && (win_id == IW'(i));
    red_in = grant ? req_data[win_id*DW +: DW] : '0;
  end

  always_comb begin
    tag_vld_d[0] = grant;
    tag_id_d[0]  = win_id;
    for (int s = 1; s < RED_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_push[i]  = tag_vld_q[RED_LAT-1] && (tag_id_q[RED_LAT-1] == IW'(i));
      resp_valid[i] = !fifo_empty[i];
      fifo_pop[i]   = resp_valid[i] && resp_ready[i];
      resp_data[i*RW +: RW] = mem_q[i][rd_ptr_q[i][AW-1:0]];
      if (fifo_push[i]) mem_d[i][wr_ptr_q[i][AW-1:0]] = red_out;
      wr_ptr_d[i] = wr_ptr_q[i] + CW'(fifo_push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + CW'(fifo_pop[i]);
      credit_d[i] = credit_q[i];
      if (req_ready[i] && !fifo_pop[i])
        credit_d[i] = credit_q[i] + 1'b1;
      else if (!req_ready[i] && fifo_pop[i])
        credit_d[i] = credit_q[i] - 1'b1;
    end
    busy = (|tag_vld_q) || !(&fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        credit_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      credit_q  <= credit_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Payload storage only; validity is carried by tag_vld_q and the FIFO pointers.
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
    mem_q    <= mem_d;
  end
endmodule

// File: tb/tb_kred_share_arb.sv
// Scoreboard bench for kred_share_arb: a behavioural reducer, a queue-based reference model
// and directed scenarios followed by randomized traffic.
module tb_kred_share_arb;
  localparam int N_REQ = 4, RED_LAT = 4, FIFO_DEPTH = 4, DW = 24, RW = 12, CW = 3;
`ifdef KRED_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ*RW-1:0] resp_data;
  logic [DW-1:0]       red_in;
  logic [RW-1:0]       red_out;
  logic                busy;

  kred_share_arb #(.N_REQ(N_REQ), .RED_LAT(RED_LAT), .FIFO_DEPTH(FIFO_DEPTH), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .red_in(red_in), .red_out(red_out), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy));

  always #5 clk = ~clk;

  // Reducer model: x mod 3329 after RED_LAT cycles; never reset, like the real datapath.
  logic [RW-1:0] red_pipe [RED_LAT];
  always @(posedge clk) begin
    red_pipe[0] <= RW'(red_in % 24'd3329);
    for (int k = 1; k < RED_LAT; k++) red_pipe[k] <= red_pipe[k-1];
  end
  assign red_out = red_pipe[RED_LAT-1];

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-lane queues of outstanding results (issued, not yet popped).
  logic [RW-1:0]    res_q [N_REQ][$];
  int               iss_q [N_REQ][$];
  int               m_ptr = 0, m_win, cand, cyc_n = 0, rv_cnt = 0;
  int               dut_gnt [N_REQ];
  int               last_iss [N_REQ];
  int               last_rsp [N_REQ];
  logic [RW-1:0]    last_rsp_data [N_REQ];
  logic [N_REQ-1:0] exp_rdy, last_rdy;
  logic [DW-1:0]    exp_in;
  logic             exp_busy, exp_v;
  logic [CW-1:0]    occ;

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        res_q[i].delete();
        iss_q[i].delete();
      end
      m_ptr = 0;
    end else begin
      m_win = -1;
      if (PRIO && req_valid[0] && res_q[0].size() < FIFO_DEPTH) m_win = 0;
      for (int k = 0; k < N_REQ; k++) begin
        cand = (m_ptr + k) % N_REQ;
        if (m_win < 0 && req_valid[cand] && res_q[cand].size() < FIFO_DEPTH && !(PRIO && cand == 0))
          m_win = cand;
      end
      exp_busy = 1'b0;
      for (int i = 0; i < N_REQ; i++) if (res_q[i].size() > 0) exp_busy = 1'b1;
      chk("busy", busy, exp_busy);
      exp_rdy = '0;
      exp_in  = '0;
      if (m_win >= 0) begin
        exp_rdy[m_win] = 1'b1;
        exp_in = req_data[m_win*DW +: DW];
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("red_in", red_in, exp_in);
      last_rdy = req_ready;
      for (int i = 0; i < N_REQ; i++) begin
        dut_gnt[i] += int'(req_ready[i]);
        if (dut.fifo_push[i]) begin
          occ = CW'(dut.wr_ptr_q[i] - dut.rd_ptr_q[i]);
          chk("fifo_push_when_full", occ == CW'(FIFO_DEPTH), 0);
        end
        exp_v = iss_q[i].size() > 0 && iss_q[i][0] + RED_LAT + 1 <= cyc_n;
        chk("resp_valid", resp_valid[i], exp_v);
        if (exp_v) chk("resp_data", resp_data[i*RW +: RW], res_q[i][0]);
        if (resp_valid[i]) rv_cnt++;
        if (resp_valid[i] && resp_ready[i]) begin
          last_rsp[i] = cyc_n;
          last_rsp_data[i] = resp_data[i*RW +: RW];
        end
        if (exp_v && resp_ready[i]) begin
          void'(res_q[i].pop_front());
          void'(iss_q[i].pop_front());
        end
      end
      if (m_win >= 0) begin
        res_q[m_win].push_back(RW'(req_data[m_win*DW +: DW] % 3329));
        iss_q[m_win].push_back(cyc_n);
        last_iss[m_win] = cyc_n;
        if (!(PRIO && m_win == 0)) m_ptr = (m_win + 1) % N_REQ;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N_REQ; i++) dut_gnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    clr_counts();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    resp_ready = '1;
    for (int i = 0; i < N_REQ; i++) begin
      last_iss[i] = -100;
      last_rsp[i] = -200;
      last_rsp_data[i] = '0;
      dut_gnt[i] = 0;
    end
    step(3);
    rst = 1'b0;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_red_in", red_in, 0);

    // Single operand: 3328^2 reduces to 1, visible RED_LAT+1 cycles after issue
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 24'd11075584;
    #1;
    chk("single_ready_same_cycle", req_ready, 4'b0010);
    chk("single_red_in", red_in, 11075584);
    step(1);
    req_valid = '0;
    step(10);
    chk("single_latency", last_rsp[1] - last_iss[1], RED_LAT + 1);
    chk("single_data", last_rsp_data[1], 1);
    chk("single_busy_idle", busy, 0);

    // All four valid every cycle
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = DW'(5000 + i);
    step(20);
    for (int i = 0; i < N_REQ; i++) chk("rr_grants_per_lane", dut_gnt[i], 5);
    req_valid = '0;
    step(10);

    // Backpressure on lane 2
    do_reset();
    req_valid = '1;
    resp_ready = 4'b1011;
    for (int c = 0; c < 30; c++) begin
      rand_data();
      step(1);
    end
    chk("bp_lane2_grants", dut_gnt[2], 4);
    chk("bp_total_grants", dut_gnt[0] + dut_gnt[1] + dut_gnt[2] + dut_gnt[3], 30);
    resp_ready = '1;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      step(1);
    end
    req_valid = '0;
    step(10);

    // Same-cycle pop and request on a lane holding full credit
    do_reset();
    req_valid = 4'b0001;
    resp_ready = 4'b1110;
    rand_data();
    step(10);
    chk("full_lane_grants", dut_gnt[0], 4);
    clr_counts();
    resp_ready = 4'b1111;
    step(1);
    chk("full_pop_cycle_refused", last_rdy, 0);
    resp_ready = 4'b1110;
    step(1);
    chk("full_next_cycle_granted", last_rdy, 4'b0001);
    step(3);
    chk("full_lane_regrants", dut_gnt[0], 1);
    req_valid = '0;
    resp_ready = '1;
    step(12);

    // Reset with three operands in flight
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      step(1);
    end
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_red_in", red_in, 0);
    rv_cnt = 0;
    step(RED_LAT);
    chk("midrst_no_stale_resp", rv_cnt, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N_REQ'($urandom);
      rand_data();
      for (int i = 0; i < N_REQ; i++) resp_ready[i] = ($urandom_range(3) != 0);
      step(1);
    end
    req_valid = '0;
    resp_ready = '1;
    step(15);
    chk("random_drained_busy", busy, 0);

`ifdef KRED_ARB_PRIO_EN
    do_reset();
    req_valid = 4'b0101;
    rand_data();
    step(4);
    chk("prio_lane0_first", (dut_gnt[0] == 4 && dut_gnt[2] == 0), 1);
    step(8);
    clr_counts();
    resp_ready = 4'b1110;
    step(10);
    chk("prio_lane0_capped", dut_gnt[0] <= 4, 1);
    chk("prio_lane2_served", dut_gnt[2] >= 4, 1);
    req_valid = '0;
    resp_ready = '1;
    step(12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
